// File: rtl/slink_deframer_pkg.sv
// Shared types and constants for the S-Link RX deframer and the matching TX framer.
package slink_deframer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_WCL = 3'd1,
    ST_HDR_WCH = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CRC_LO  = 3'd4,
    ST_CRC_HI  = 3'd5
  } deframer_state_e;

  localparam logic [15:0] SLINK_CRC16_POLY  = 16'h1021;
  localparam logic [15:0] SLINK_CRC16_INIT  = 16'hFFFF;
  localparam logic [7:0]  SLINK_LONG_DI_MIN = 8'h30;

endpackage

// File: rtl/slink_crc16_byte.sv
// One-byte step of CRC-16/CCITT-FALSE, MSB of the byte first, no reflection.
module slink_crc16_byte
  import slink_deframer_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] crc_o
);

  // Shift the eight data bits through the LFSR, most significant first.
  always_comb begin
    crc_o = crc_i;
    for (int i = 7; i >= 0; i--) begin
      if (crc_o[15] ^ byte_i[i]) begin
        crc_o = {crc_o[14:0], 1'b0} ^ SLINK_CRC16_POLY;
      end else begin
        crc_o = {crc_o[14:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/slink_rx_deframer.sv
// S-Link RX deframer: parses the 3-byte header, packs long-packet payload into
// words, holds the final word until the trailing CRC-16 has been checked.
module slink_rx_deframer
  import slink_deframer_pkg::*;
#(
  parameter int         APP_DATA_WIDTH = 32,
  parameter logic [7:0] LONG_DI_MIN    = SLINK_LONG_DI_MIN
) (
  input  logic                      link_clk,
  input  logic                      link_reset,
  input  logic                      ll_rx_valid,
  input  logic                      ll_rx_sop,
  input  logic [7:0]                ll_rx_byte,
  output logic                      rx_sop,
  output logic [7:0]                rx_data_id,
  output logic [15:0]               rx_word_count,
  output logic [APP_DATA_WIDTH-1:0] rx_app_data,
  output logic                      rx_valid,
  output logic                      rx_crc_corrupted,
  output logic                      rx_pkt_abort
);

  localparam int BPW   = APP_DATA_WIDTH / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);

  deframer_state_e           state_q, state_d;
  logic [7:0]                di_q, di_d;
  logic [15:0]               wc_q, wc_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [APP_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      first_q, first_d;
  logic [15:0]               crc_q, crc_d;
  logic [7:0]                crc_lo_q, crc_lo_d;

  logic                      rx_sop_q, rx_valid_q, rx_crc_corrupted_q, rx_pkt_abort_q;
  logic [7:0]                rx_data_id_q;
  logic [15:0]               rx_word_count_q;
  logic [APP_DATA_WIDTH-1:0] rx_app_data_q;

  logic [15:0]               crc_next_s;
  logic [APP_DATA_WIDTH-1:0] word_s;
  logic [APP_DATA_WIDTH-1:0] emit_data_s;
  logic                      emit_s, emit_sop_s, emit_bad_s, abort_s;

  slink_crc16_byte u_crc (
    .crc_i  (crc_q),
    .byte_i (ll_rx_byte),
    .crc_o  (crc_next_s)
  );

  // Next-state, header/payload datapath and word emission decisions.
  always_comb begin
    state_d     = state_q;
    di_d        = di_q;
    wc_d        = wc_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    first_d     = first_q;
    crc_d       = crc_q;
    crc_lo_d    = crc_lo_q;
    emit_s      = 1'b0;
    emit_sop_s  = 1'b0;
    emit_bad_s  = 1'b0;
    emit_data_s = '0;
    abort_s     = 1'b0;
    word_s      = acc_q;
    word_s[{idx_q, 3'b000} +: 8] = ll_rx_byte;

    if (ll_rx_valid && ll_rx_sop) begin
      // A DI byte always restarts parsing; mid-packet it also drops the held word.
      abort_s = (state_q != ST_IDLE);
      di_d    = ll_rx_byte;
      acc_d   = '0;
      idx_d   = '0;
      first_d = 1'b1;
      crc_d   = SLINK_CRC16_INIT;
      state_d = ST_HDR_WCL;
    end else if (ll_rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_HDR_WCL: begin
          wc_d[7:0] = ll_rx_byte;
          state_d   = ST_HDR_WCH;
        end
        ST_HDR_WCH: begin
          wc_d[15:8] = ll_rx_byte;
          cnt_d      = {ll_rx_byte, wc_q[7:0]};
          if (di_q < LONG_DI_MIN) begin
            emit_s     = 1'b1;
            emit_sop_s = 1'b1;
            state_d    = ST_IDLE;
          end else if ({ll_rx_byte, wc_q[7:0]} == 16'd0) begin
            state_d = ST_CRC_LO;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          cnt_d = cnt_q - 16'd1;
          crc_d = crc_next_s;
          if (cnt_q == 16'd1) begin
            acc_d   = word_s;
            state_d = ST_CRC_LO;
          end else if (idx_q == IDX_LAST) begin
            emit_s      = 1'b1;
            emit_sop_s  = first_q;
            emit_data_s = word_s;
            first_d     = 1'b0;
            acc_d       = '0;
            idx_d       = '0;
          end else begin
            acc_d = word_s;
            idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
        ST_CRC_LO: begin
          crc_lo_d = ll_rx_byte;
          state_d  = ST_CRC_HI;
        end
        ST_CRC_HI: begin
          emit_s      = 1'b1;
          emit_sop_s  = first_q;
          emit_data_s = acc_q;
          emit_bad_s  = ({ll_rx_byte, crc_lo_q} != crc_q);
          state_d     = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, datapath and registered application-side outputs.
  always_ff @(posedge link_clk) begin
    if (link_reset) begin
      state_q            <= ST_IDLE;
      di_q               <= 8'h00;
      wc_q               <= 16'h0000;
      cnt_q              <= 16'h0000;
      acc_q              <= '0;
      idx_q              <= '0;
      first_q            <= 1'b0;
      crc_q              <= 16'h0000;
      crc_lo_q           <= 8'h00;
      rx_sop_q           <= 1'b0;
      rx_valid_q         <= 1'b0;
      rx_crc_corrupted_q <= 1'b0;
      rx_pkt_abort_q     <= 1'b0;
      rx_data_id_q       <= 8'h00;
      rx_word_count_q    <= 16'h0000;
      rx_app_data_q      <= '0;
    end else begin
      state_q            <= state_d;
      di_q               <= di_d;
      wc_q               <= wc_d;
      cnt_q              <= cnt_d;
      acc_q              <= acc_d;
      idx_q              <= idx_d;
      first_q            <= first_d;
      crc_q              <= crc_d;
      crc_lo_q           <= crc_lo_d;
      rx_valid_q         <= emit_s;
      rx_sop_q           <= emit_s & emit_sop_s;
      rx_crc_corrupted_q <= emit_s & emit_bad_s;
      rx_pkt_abort_q     <= abort_s;
      if (emit_s) begin
        rx_app_data_q   <= emit_data_s;
        rx_data_id_q    <= di_q;
        rx_word_count_q <= wc_d;
      end
    end
  end

  assign rx_sop           = rx_sop_q;
  assign rx_data_id       = rx_data_id_q;
  assign rx_word_count    = rx_word_count_q;
  assign rx_app_data      = rx_app_data_q;
  assign rx_valid         = rx_valid_q;
  assign rx_crc_corrupted = rx_crc_corrupted_q;
  assign rx_pkt_abort     = rx_pkt_abort_q;

endmodule

// File: tb/tb_slink_rx_deframer.sv
// Scoreboard bench for slink_rx_deframer: the byte driver predicts every output
// word and abort pulse (with its cycle); a negedge monitor pops and compares.
module tb_slink_rx_deframer;

  localparam int BPW = 4;

  logic        link_clk;
  logic        link_reset;
  logic        ll_rx_valid;
  logic        ll_rx_sop;
  logic [7:0]  ll_rx_byte;
  logic        rx_sop;
  logic [7:0]  rx_data_id;
  logic [15:0] rx_word_count;
  logic [31:0] rx_app_data;
  logic        rx_valid;
  logic        rx_crc_corrupted;
  logic        rx_pkt_abort;

  slink_rx_deframer #(.APP_DATA_WIDTH(32), .LONG_DI_MIN(8'h30)) dut (
    .link_clk         (link_clk),
    .link_reset       (link_reset),
    .ll_rx_valid      (ll_rx_valid),
    .ll_rx_sop        (ll_rx_sop),
    .ll_rx_byte       (ll_rx_byte),
    .rx_sop           (rx_sop),
    .rx_data_id       (rx_data_id),
    .rx_word_count    (rx_word_count),
    .rx_app_data      (rx_app_data),
    .rx_valid         (rx_valid),
    .rx_crc_corrupted (rx_crc_corrupted),
    .rx_pkt_abort     (rx_pkt_abort)
  );

  typedef struct packed {
    int          cyc;
    logic        sop;
    logic [7:0]  di;
    logic [15:0] wc;
    logic [31:0] data;
    logic        bad;
  } exp_t;

  exp_t       exp_q[$];
  int         abort_q[$];
  exp_t       e;
  int         cyc = 0;
  int         last_cyc = 0;
  bit         in_pkt = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] pl [0:511];

  initial link_clk = 1'b0;
  always #5 link_clk = ~link_clk;

  always @(posedge link_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    repeat (8) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // Output monitor: compares every word and abort pulse against the scoreboard.
  always @(negedge link_clk) begin
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'(rx_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("valid_cycle", 64'(cyc), 64'(e.cyc));
        chk("sop", 64'(rx_sop), 64'(e.sop));
        chk("data_id", 64'(rx_data_id), 64'(e.di));
        chk("word_count", 64'(rx_word_count), 64'(e.wc));
        chk("app_data", 64'(rx_app_data), 64'(e.data));
        chk("crc_corrupted", 64'(rx_crc_corrupted), 64'(e.bad));
      end
    end
    if (rx_sop && !rx_valid) chk("sop_without_valid", 64'(rx_valid), 64'd1);
    if (rx_crc_corrupted && !rx_valid) chk("crc_without_valid", 64'(rx_valid), 64'd1);
    if (rx_pkt_abort) begin
      if (abort_q.size() == 0) chk("unexpected_abort", 64'(rx_pkt_abort), 64'd0);
      else chk("abort_cycle", 64'(cyc), 64'(abort_q.pop_front()));
    end
  end

  task automatic idle();
    @(posedge link_clk); #1;
    ll_rx_valid = 1'b0;
    ll_rx_sop   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sop, input bit gaps);
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) idle();
    end
    @(posedge link_clk); #1;
    ll_rx_valid = 1'b1;
    ll_rx_sop   = sop;
    ll_rx_byte  = b;
    last_cyc    = cyc;
    if (sop && in_pkt) abort_q.push_back(cyc + 1);
  endtask

  // Drives one packet; n_pl < wc truncates a long packet (no CRC sent).
  task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc, input int n_pl,
                          input bit force_crc, input logic [15:0] crc_rx, input bit gaps);
    logic [15:0] crc;
    logic [15:0] sent;
    logic [31:0] acc;
    logic        first;
    send_byte(di, 1'b1, gaps);
    in_pkt = 1'b1;
    send_byte(wc[7:0], 1'b0, gaps);
    send_byte(wc[15:8], 1'b0, gaps);
    if (di < 8'h30) begin
      exp_q.push_back('{last_cyc + 1, 1'b1, di, wc, 32'h0, 1'b0});
      in_pkt = 1'b0;
      return;
    end
    crc   = 16'hFFFF;
    acc   = 32'h0;
    first = 1'b1;
    for (int k = 0; k < n_pl; k++) begin
      send_byte(pl[k], 1'b0, gaps);
      crc = crc_upd(crc, pl[k]);
      acc[(k % BPW) * 8 +: 8] = pl[k];
      if ((k % BPW) == BPW - 1 && k != int'(wc) - 1) begin
        exp_q.push_back('{last_cyc + 1, first, di, wc, acc, 1'b0});
        first = 1'b0;
        acc   = 32'h0;
      end
    end
    if (n_pl < int'(wc)) return;
    sent = force_crc ? crc_rx : crc;
    send_byte(sent[7:0], 1'b0, gaps);
    send_byte(sent[15:8], 1'b0, gaps);
    exp_q.push_back('{last_cyc + 1, first, di, wc, acc, (sent != crc)});
    in_pkt = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_sop"}, 64'(rx_sop), 64'd0);
    chk({tag, "_valid"}, 64'(rx_valid), 64'd0);
    chk({tag, "_data_id"}, 64'(rx_data_id), 64'd0);
    chk({tag, "_word_count"}, 64'(rx_word_count), 64'd0);
    chk({tag, "_app_data"}, 64'(rx_app_data), 64'd0);
    chk({tag, "_crc_corrupted"}, 64'(rx_crc_corrupted), 64'd0);
    chk({tag, "_abort"}, 64'(rx_pkt_abort), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge link_clk); #1;
    link_reset  = 1'b1;
    ll_rx_valid = 1'b0;
    ll_rx_sop   = 1'b0;
    repeat (2) @(posedge link_clk);
    @(negedge link_clk);
    check_outputs_zero(tag);
    @(posedge link_clk); #1;
    link_reset = 1'b0;
    in_pkt     = 1'b0;
  endtask

  task automatic load_vector();
    for (int k = 0; k < 9; k++) pl[k] = 8'h31 + 8'(k);
  endtask

  initial begin
    link_reset  = 1'b1;
    ll_rx_valid = 1'b0;
    ll_rx_sop   = 1'b0;
    ll_rx_byte  = 8'h00;
    do_reset("reset");

    // Stray byte outside a packet must be ignored.
    send_byte(8'hAA, 1'b0, 1'b0);
    idle();

    send_pkt(8'h05, 16'h1234, 0, 1'b0, 16'h0000, 1'b0);
    load_vector();
    send_pkt(8'h30, 16'h0009, 9, 1'b1, 16'h29B1, 1'b0);
    send_pkt(8'h30, 16'h0009, 9, 1'b1, 16'h28B1, 1'b0);
    send_pkt(8'h31, 16'h0000, 0, 1'b1, 16'hFFFF, 1'b0);
    repeat (2) idle();

    for (int k = 0; k < 16; k++) pl[k] = 8'($urandom);
    send_pkt(8'h32, 16'h0010, 6, 1'b0, 16'h0000, 1'b0);
    send_pkt(8'h33, 16'h0005, 5, 1'b0, 16'h0000, 1'b0);
    send_pkt(8'h06, 16'hBEEF, 0, 1'b0, 16'h0000, 1'b0);

    for (int k = 0; k < 256; k++) pl[k] = 8'($urandom);
    send_pkt(8'h3A, 16'h0100, 256, 1'b0, 16'h0000, 1'b0);
    send_pkt(8'h3A, 16'h0100, 256, 1'b0, 16'h0000, 1'b1);
    send_pkt(8'h07, 16'h0042, 0, 1'b0, 16'h0000, 1'b1);
    repeat (3) idle();

    send_pkt(8'h34, 16'h0100, 10, 1'b0, 16'h0000, 1'b0);
    repeat (3) idle();
    do_reset("midreset");
    send_pkt(8'h12, 16'hABCD, 0, 1'b0, 16'h0000, 1'b0);
    load_vector();
    send_pkt(8'h30, 16'h0009, 9, 1'b1, 16'h29B1, 1'b0);

    repeat (20) idle();
    chk("pending_words", 64'(exp_q.size()), 64'd0);
    chk("pending_aborts", 64'(abort_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
